image_streamer: RTL and testbench
=================================

IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 SHALL have parameter IMG_DIM, default 64, meaning image side length in pixels; supported value 64 only, which fixes the 6-bit coordinates.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  frame request, connected to the processing stage's filter_done.
REQ-005 SHALL have port in_pix  input  24  output-image pixel at [row,col] (R 23:16, G 15:8, B 7:0).
REQ-006 SHALL have port row  output  6  output-image read row address, registered.
REQ-007 SHALL have port col  output  6  output-image read column address, registered.
REQ-008 SHALL have port m_valid  output  1  byte-stream data valid.
REQ-009 SHALL have port m_ready  input  1  byte-stream sink ready.
REQ-010 SHALL have port m_data  output  8  byte-stream payload.
REQ-011 SHALL have port m_last  output  1  marks the final byte of the frame.
REQ-012 SHALL have port done  output  1  frame fully transferred, level.
REQ-013 SHALL have port checksum  output  16  sum of all transferred bytes, mod 2^16.

Function
REQ-014 SHALL treat in_pix as valid one cycle after row/col change, and sample it at the following rising edge.
REQ-015 SHALL stream pixels in row-major order, (0,0) first and (63,63) last, as 3 bytes per pixel in R, G, B order; 12288 bytes per frame.
REQ-016 SHALL implement states IDLE, ADDR, LOAD, SEND_R, SEND_G, SEND_B, DONE.
REQ-017 SHALL, in IDLE or DONE with start=1, clear row, col, checksum and done, and go to ADDR.
REQ-018 SHALL go ADDR->LOAD unconditionally; LOAD captures in_pix for pixel (0,0) into the current-pixel register and goes to SEND_R.
REQ-019 SHALL hold m_valid=1 in the SEND_* states only; in each SEND_* state, m_data is the corresponding channel of the current pixel.
REQ-020 SHALL advance SEND_R->SEND_G->SEND_B only on a handshake, i.e. a rising edge with m_valid=1 and m_ready=1; otherwise it holds state, with m_data and m_last stable.
REQ-021 SHALL, on the edge entering SEND_R, advance row/col to the next pixel (col wraps 63->0 and increments row), unless the current pixel is (63,63).
REQ-022 SHALL capture in_pix into a prefetch register at the first edge spent in SEND_R for each pixel, whether or not a handshake occurs on that edge.
REQ-023 SHALL, on a SEND_B handshake, go to SEND_R with current pixel = prefetch if the pixel was not (63,63), else go to DONE.
REQ-024 SHALL sustain 1 byte/cycle with m_ready held high; a frame takes 2 + 12288 cycles from start to the final handshake.
REQ-025 SHALL assert m_last only in SEND_B of pixel (63,63).
REQ-026 SHALL add m_data, zero-extended, to checksum on every handshake, with 16-bit wrap-around.
REQ-027 SHALL, in DONE, hold done=1, m_valid=0 and a stable checksum until a new start.
REQ-028 SHALL ignore start in ADDR, LOAD and SEND_*.
REQ-029 SHALL ignore m_ready while m_valid=0.
REQ-030 SHALL keep row/col at (63,63) after the last pixel and not wrap them.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-frame, immediately force state IDLE; row=0, col=0, m_valid=0, m_data=0, m_last=0, done=0, checksum=0; pixel and prefetch registers to 0.
REQ-032 SHALL, after rst deasserts, emit nothing until a new start, and restart any aborted frame at pixel (0,0).

Structure
REQ-033 SHALL place IMG_DIM, BYTES_PER_PIX=3, FRAME_BYTES=12288 and the state encoding in the shared image package.
REQ-034 SHALL place the 3-byte R/G/B channel select plus m_data/m_last generation in one sub-module, pix_byte_ser.

Verification
REQ-035 SHALL cover: memory pix(r,c)={r,c,8'hA5}, start pulse, m_ready=1 -> 12288 bytes; first bytes 00,00,A5,00,01,A5; last byte A5 with m_last=1; done at cycle 12290+1.
REQ-036 SHALL cover: all pixels 24'hFFFFFF, m_ready=1 -> checksum = (12288*255) mod 65536 = 16'hD000, done=1.
REQ-037 SHALL cover: m_ready toggled pseudo-randomly -> byte sequence identical to the m_ready=1 run, m_data/m_last stable while m_valid=1 and m_ready=0, checksum identical.
REQ-038 SHALL cover: rst pulsed after byte 5000 -> all outputs zero within the reset cycle; new start -> stream restarts at pixel (0,0) byte R.
REQ-039 SHALL cover: start pulsed mid-frame -> no effect on sequence or count; start in DONE -> done drops next edge, second identical frame.
REQ-040 SHALL cover: m_ready=0 held 100 cycles in SEND_R of pixel (0,63) -> row/col stay (1,0), prefetch = pix(1,0), next pixel bytes correct.

Source files
------------

// File: rtl/image_streamer_pkg.sv
// Shared constants and types for the image byte streamer: frame geometry,
// pixel layout and the streaming FSM state encoding.
package image_streamer_pkg;

  localparam int IMG_DIM       = 64;
  localparam int COORD_W       = 6;
  localparam int BYTES_PER_PIX = 3;
  localparam int FRAME_BYTES   = IMG_DIM * IMG_DIM * BYTES_PER_PIX;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LOAD,
    SEND_R,
    SEND_G,
    SEND_B,
    DONE
  } state_t;

endpackage

// File: rtl/image_streamer_if.sv
// Byte-stream valid/ready channel carrying the serialised image.
interface image_streamer_if;

  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/pix_byte_ser.sv
// Selects the R, G or B byte of the current pixel for the active SEND_* state
// and flags the final byte of the frame.
module pix_byte_ser
  import image_streamer_pkg::*;
(
  input  state_t     state,
  input  pixel_t     pix,
  input  logic       pix_last,
  output logic [7:0] data,
  output logic       last
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    data = 8'h00;
    last = 1'b0;
    case (state)
      SEND_R: data = pix.r;
      SEND_G: data = pix.g;
      SEND_B: begin
        data = pix.b;
        last = pix_last;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/image_streamer.sv
// Reads a 64x64 RGB image in row-major order and streams it as R,G,B bytes
// over a valid/ready channel, prefetching the next pixel while sending.
module image_streamer #(
  parameter int IMG_DIM = image_streamer_pkg::IMG_DIM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [23:0]          in_pix,
  output logic [5:0]           row,
  output logic [5:0]           col,
  output logic                 done,
  output logic [15:0]          checksum,
  image_streamer_if.master     m
);
  import image_streamer_pkg::*;

  localparam coord_t LAST_COORD = COORD_W'(IMG_DIM - 1);
  localparam int     SENT_W     = $clog2(FRAME_BYTES);

  state_t              state;
  pixel_t              pix;
  pixel_t              prefetch;
  logic                pix_last;
  logic                prefetch_due;
  logic                valid_q;
  logic                handshake;
  logic                at_end;
  coord_t              next_row;
  coord_t              next_col;
  logic [SENT_W-1:0]   sent;

  assign handshake = valid_q & m.m_ready;
  assign at_end    = (row == LAST_COORD) && (col == LAST_COORD);
  assign m.m_valid = valid_q;

  // Address of the pixel after the one now at row/col; parks on the last one.
  always_comb begin
    next_row = row;
    next_col = col;
    if (!at_end) begin
      if (col == LAST_COORD) begin
        next_col = '0;
        next_row = row + 1'b1;
      end else begin
        next_col = col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: pixel/prefetch are plain registers, not a memory, so they reset too.
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      valid_q      <= 1'b0;
      done         <= 1'b0;
      checksum     <= '0;
      pix          <= '0;
      prefetch     <= '0;
      pix_last     <= 1'b0;
      prefetch_due <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      if (handshake) checksum <= checksum + {8'h00, m.m_data};

      case (state)
        IDLE, DONE: begin
          if (start) begin
            row      <= '0;
            col      <= '0;
            checksum <= '0;
            done     <= 1'b0;
            state    <= ADDR;
          end
        end

        ADDR: state <= LOAD;

        LOAD: begin
          pix          <= pixel_t'(in_pix);
          pix_last     <= at_end;
          prefetch_due <= 1'b1;
          valid_q      <= 1'b1;
          row          <= next_row;
          col          <= next_col;
          state        <= SEND_R;
        end

        SEND_R: begin
          // Address moved on entry, so in_pix already holds the next pixel.
          if (prefetch_due) begin
            prefetch     <= pixel_t'(in_pix);
            prefetch_due <= 1'b0;
          end
          if (handshake) state <= SEND_G;
        end

        SEND_G: if (handshake) state <= SEND_B;

        SEND_B: begin
          if (handshake) begin
            if (pix_last) begin
              valid_q <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              pix          <= prefetch;
              pix_last     <= at_end;
              prefetch_due <= 1'b1;
              row          <= next_row;
              col          <= next_col;
              state        <= SEND_R;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  pix_byte_ser u_ser (
    .state    (state),
    .pix      (pix),
    .pix_last (pix_last),
    .data     (m.m_data),
    .last     (m.m_last)
  );

  // Bytes accepted in the current frame; only observed by the checks below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent <= '0;
    end else if ((state == IDLE || state == DONE) && start) begin
      sent <= '0;
    end else if (handshake) begin
      sent <= sent + 1'b1;
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (m.m_valid && !m.m_ready) |=> (m.m_valid && $stable(m.m_data) && $stable(m.m_last)));

  a_done_idle: assert property (@(posedge clk) disable iff (rst)
    done |-> !m.m_valid);

  a_last_count: assert property (@(posedge clk) disable iff (rst)
    m.m_last |-> (sent == SENT_W'(FRAME_BYTES - 1)));

endmodule

// File: tb/tb_image_streamer.sv
// Self-checking bench for image_streamer: a byte-level frame model checks every
// handshake, while directed frames pin timing, stalls, resets and checksums.
module tb_image_streamer;

  localparam int N_BYTES = 64 * 64 * 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] in_pix;
  logic [5:0]  row;
  logic [5:0]  col;
  logic        done;
  logic [15:0] checksum;

  image_streamer_if bus ();

  image_streamer #(.IMG_DIM(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_pix   (in_pix),
    .row      (row),
    .col      (col),
    .done     (done),
    .checksum (checksum),
    .m        (bus)
  );

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          pattern    = 0;
  int          ready_mode = 0;
  int          byte_idx   = 0;
  logic [15:0] model_sum  = '0;
  logic [7:0]  rx_log [N_BYTES];
  logic        stalled    = 1'b0;
  logic [7:0]  held_data  = '0;
  logic        held_last  = 1'b0;

  always #5 clk = ~clk;

  // Image contents: pattern 0 is {row, col, A5}, pattern 1 is all white.
  function automatic logic [23:0] pix_fn(input int pat, input int r, input int c);
    if (pat == 1) return 24'hFFFFFF;
    return {8'(r), 8'(c), 8'hA5};
  endfunction

  // Byte n of the frame: pixel n/3 in row-major order, channel n%3 as R,G,B.
  function automatic logic [7:0] exp_byte(input int pat, input int idx);
    logic [23:0] px;
    px = pix_fn(pat, (idx / 3) / 64, (idx / 3) % 64);
    case (idx % 3)
      0:       return px[23:16];
      1:       return px[15:8];
      default: return px[7:0];
    endcase
  endfunction

  assign in_pix = pix_fn(pattern, int'(row), int'(col));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_row"},      row,         0);
    check({tag, "_col"},      col,         0);
    check({tag, "_valid"},    bus.m_valid, 0);
    check({tag, "_data"},     bus.m_data,  0);
    check({tag, "_last"},     bus.m_last,  0);
    check({tag, "_done"},     done,        0);
    check({tag, "_checksum"}, checksum,    0);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic new_frame();
    byte_idx  = 0;
    model_sum = '0;
    pulse_start();
  endtask

  task automatic wait_done(input int bound, output int edges);
    edges = 0;
    while (!done && edges < bound) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!done) check("done_timeout", done, 1);
  endtask

  task automatic check_frame_end(input string tag, input logic [15:0] exp_sum);
    check({tag, "_byte_count"},   byte_idx,    N_BYTES);
    check({tag, "_checksum"},     checksum,    exp_sum);
    check({tag, "_checksum_mdl"}, checksum,    model_sum);
    check({tag, "_valid_off"},    bus.m_valid, 0);
  endtask

  // m_ready source: held high, pseudo-random, or held low.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b0;
    endcase
  end

  // Compare process: each byte accepted at the next rising edge is checked
  // against the frame model; stalled bytes must not change.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else if (bus.m_valid) begin
      if (stalled) begin
        check("stall_data", bus.m_data, held_data);
        check("stall_last", bus.m_last, held_last);
      end
      if (bus.m_ready) begin
        stalled = 1'b0;
        if (byte_idx < N_BYTES) begin
          check("stream_byte", bus.m_data, exp_byte(pattern, byte_idx));
          check("stream_last", bus.m_last, byte_idx == N_BYTES - 1);
          rx_log[byte_idx] = bus.m_data;
          model_sum        = model_sum + 16'(bus.m_data);
          byte_idx++;
        end else begin
          check("extra_byte", byte_idx, N_BYTES - 1);
        end
      end else begin
        stalled   = 1'b1;
        held_data = bus.m_data;
        held_last = bus.m_last;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    int edges;
    rst         = 1'b1;
    start       = 1'b0;
    bus.m_ready = 1'b1;

    // Reset state, then idle with m_ready high: nothing may be emitted.
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_valid",    bus.m_valid, 0);
    check("idle_checksum", checksum,    0);

    // Frame A: {r,c,A5}, m_ready high.
    new_frame();
    wait_done(20000, edges);
    check("done_latency", edges, 12290);
    check_frame_end("frame_a", 16'h4000);
    check("first_b0", rx_log[0], 8'h00);
    check("first_b1", rx_log[1], 8'h00);
    check("first_b2", rx_log[2], 8'hA5);
    check("first_b3", rx_log[3], 8'h00);
    check("first_b4", rx_log[4], 8'h01);
    check("first_b5", rx_log[5], 8'hA5);
    check("final_byte", rx_log[N_BYTES - 1], 8'hA5);
    check("model_sum_a", model_sum, 16'h4000);
    check("end_row", row, 6'd63);
    check("end_col", col, 6'd63);
    repeat (5) @(posedge clk);
    #1;
    check("done_hold",     done,     1);
    check("checksum_hold", checksum, 16'h4000);
    check("done_addr_row", row,      6'd63);

    // Frame B: started from DONE, random m_ready, stray start mid-frame.
    ready_mode = 1;
    new_frame();
    check("done_drop", done, 0);
    repeat (3000) @(posedge clk);
    pulse_start();
    wait_done(40000, edges);
    check_frame_end("frame_b", 16'h4000);

    // Frame C: 100-cycle stall on the R byte of pixel (0,63).
    ready_mode = 0;
    new_frame();
    repeat (190) @(posedge clk);
    @(negedge clk);
    ready_mode = 2;
    @(negedge clk);
    check("stall_at_byte", byte_idx, 189);
    check("stall_row", row, 6'd1);
    check("stall_col", col, 6'd0);
    repeat (99) @(negedge clk);
    check("stall_row_end",   row,         6'd1);
    check("stall_col_end",   col,         6'd0);
    check("stall_valid_end", bus.m_valid, 1);
    check("stall_data_end",  bus.m_data,  8'h00);
    check("stall_count_end", byte_idx,    189);
    ready_mode = 0;
    wait_done(20000, edges);
    check_frame_end("frame_c", 16'h4000);
    check("pix063_r", rx_log[189], 8'h00);
    check("pix063_g", rx_log[190], 8'h3F);
    check("pix063_b", rx_log[191], 8'hA5);
    check("pix100_r", rx_log[192], 8'h01);
    check("pix100_g", rx_log[193], 8'h00);
    check("pix100_b", rx_log[194], 8'hA5);

    // Frame D: all-white image.
    pattern = 1;
    new_frame();
    wait_done(20000, edges);
    check_frame_end("frame_d", 16'hD000);
    check("model_sum_d", model_sum, 16'hD000);

    // Frame E: reset after byte 5000, then a fresh frame from (0,0).
    pattern = 0;
    new_frame();
    edges = 0;
    while (byte_idx <= 5000 && edges < 20000) begin
      @(negedge clk);
      edges++;
    end
    check("reach_5000", byte_idx > 5000, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    byte_idx  = 0;
    model_sum = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_valid", bus.m_valid, 0);
    check("post_reset_count", byte_idx,    0);
    new_frame();
    wait_done(20000, edges);
    check_frame_end("frame_e", 16'h4000);
    check("restart_b0", rx_log[0], 8'h00);
    check("restart_b1", rx_log[1], 8'h00);
    check("restart_b2", rx_log[2], 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
